// File: rtl/mlc_pkg.sv
// mlc_pkg: default widths (Q_WIDTH, LAYER_WIDTH, S_WIDTH) and the layer_t type shared by multilayer_counter and mlc_layer
package mlc_pkg;
  localparam int Q_WIDTH = 8;
  localparam int LAYER_WIDTH = 4;
  localparam int S_WIDTH = 6;
  typedef logic [LAYER_WIDTH-1:0] layer_t;
endpackage

// File: rtl/mlc_layer.sv
// mlc_layer: one counter layer (c clock, r async active-low reset, ci carry-in/increment, q layer count, co carry-out = ci & all-ones)
module mlc_layer
  import mlc_pkg::*;
#(
  parameter int W = LAYER_WIDTH
) (
  input  logic         c,
  input  logic         r,
  input  logic         ci,
  output logic [W-1:0] q,
  output logic         co
);
  always_ff @(posedge c or negedge r)
    if (!r) q <= '0;
    else if (ci) q <= q + 1'b1;
  assign co = ci & (&q);
endmodule

// File: rtl/multilayer_counter.sv
// multilayer_counter: prescaled layered up-counter (c clock, r async active-low reset, ce enable, s prescale select, q count); prescaler built only with MLC_PRESCALE_EN
module multilayer_counter
  import mlc_pkg::*;
#(
  parameter int Q_WIDTH = mlc_pkg::Q_WIDTH,
  parameter int LAYER_WIDTH = mlc_pkg::LAYER_WIDTH,
  parameter int S_WIDTH = mlc_pkg::S_WIDTH
) (
  input  logic               c,
  input  logic               r,
  input  logic               ce,
  input  logic [S_WIDTH-1:0] s,
  output logic [Q_WIDTH-1:0] q
);
  localparam int N = Q_WIDTH / LAYER_WIDTH;
  logic tick;
  logic [N:0] cy;
  logic unused_wrap;
`ifdef MLC_PRESCALE_EN
  logic [S_WIDTH-1:0] p;
  always_ff @(posedge c or negedge r)
    if (!r) p <= '0;
    else if (ce) p <= (p >= s) ? '0 : p + 1'b1;
  assign tick = ce & (p >= s);
`else
  logic unused_s;
  assign unused_s = ^s;
  assign tick = ce;
`endif
  assign cy[0] = tick;
  assign unused_wrap = cy[N];
  for (genvar g = 0; g < N; g++) begin : g_layer
    mlc_layer #(.W(LAYER_WIDTH)) u_layer (
      .c (c),
      .r (r),
      .ci(cy[g]),
      .q (q[g*LAYER_WIDTH +: LAYER_WIDTH]),
      .co(cy[g+1])
    );
  end
endmodule

// File: tb/tb_multilayer_counter.sv
// tb_multilayer_counter: vector table, corner sequences and randomized run against a behavioural count model
module tb_multilayer_counter;
`ifdef MLC_PRESCALE_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  logic c = 1'b0;
  logic r = 1'b0;
  logic ce = 1'b0;
  logic [5:0] s = '0;
  logic [7:0] q;
  int total = 0;
  int bad = 0;
  int mp = 0;
  int mq = 0;
  typedef struct {
    logic r;
    logic ce;
    logic [5:0] s;
    int n;
    logic [7:0] e_pre;
    logic [7:0] e_nopre;
    string name;
  } vec_t;
  vec_t tbl[13];
  multilayer_counter dut (.c(c), .r(r), .ce(ce), .s(s), .q(q));
  always #5 c = ~c;
  always @(posedge c or negedge r)
    if (!r) begin
      mp = 0;
      mq = 0;
    end else if (ce) begin
      if (!PEN || mp >= int'(s)) begin
        mp = 0;
        mq = (mq + 1) % 256;
      end else mp = mp + 1;
    end
  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: q=%0d expected %0d", name, got, exp);
    end
  endtask
  task automatic drive(input logic r_, input logic ce_, input logic [5:0] s_, input int n);
    r = r_;
    ce = ce_;
    s = s_;
    repeat (n) @(negedge c);
  endtask
  initial begin
    tbl[0]  = '{1'b0, 1'b1, 6'd5, 3,   8'd0,  8'd0,  "rst_hold"};
    tbl[1]  = '{1'b1, 1'b1, 6'd0, 20,  8'd20, 8'd20, "s0_20"};
    tbl[2]  = '{1'b1, 1'b1, 6'd0, 236, 8'd0,  8'd0,  "s0_wrap"};
    tbl[3]  = '{1'b0, 1'b1, 6'd0, 1,   8'd0,  8'd0,  "rst_a"};
    tbl[4]  = '{1'b1, 1'b1, 6'd1, 12,  8'd6,  8'd12, "s1_12"};
    tbl[5]  = '{1'b0, 1'b1, 6'd0, 1,   8'd0,  8'd0,  "rst_b"};
    tbl[6]  = '{1'b1, 1'b1, 6'd2, 12,  8'd4,  8'd12, "s2_12"};
    tbl[7]  = '{1'b0, 1'b1, 6'd0, 1,   8'd0,  8'd0,  "rst_c"};
    tbl[8]  = '{1'b1, 1'b0, 6'd0, 5,   8'd0,  8'd0,  "ce_off"};
    tbl[9]  = '{1'b1, 1'b1, 6'd3, 3,   8'd0,  8'd3,  "s3_pre"};
    tbl[10] = '{1'b1, 1'b0, 6'd3, 4,   8'd0,  8'd3,  "s3_ce_off"};
    tbl[11] = '{1'b1, 1'b1, 6'd3, 1,   8'd1,  8'd4,  "s3_tick"};
    tbl[12] = '{1'b1, 1'b1, 6'd7, 8,   8'd2,  8'd12, "s7_8"};
    @(negedge c);
    check("reset_init", q, 8'd0);
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].r, tbl[i].ce, tbl[i].s, tbl[i].n);
      check(tbl[i].name, q, PEN ? tbl[i].e_pre : tbl[i].e_nopre);
    end
    drive(1'b0, 1'b1, 6'd0, 1);
    drive(1'b1, 1'b1, 6'd0, 15);
    check("carry_0f", q, 8'h0f);
    drive(1'b1, 1'b1, 6'd0, 1);
    check("carry_10", q, 8'h10);
    @(posedge c);
    #2 r = 1'b0;
    #1 check("async_mid", q, 8'd0);
    @(negedge c);
    drive(1'b1, 1'b1, 6'd2, 2);
    check("s2_p2", q, PEN ? 8'd0 : 8'd2);
    drive(1'b1, 1'b1, 6'd1, 1);
    check("s_drop_tick", q, PEN ? 8'd1 : 8'd3);
    drive(1'b1, 1'b1, 6'd1, 2);
    check("s1_period", q, PEN ? 8'd2 : 8'd5);
    drive(1'b1, 1'b1, 6'd0, 3);
    check("s0_every", q, PEN ? 8'd5 : 8'd8);
    drive(1'b1, 1'b1, 6'd0, 1);
    drive(1'b1, 1'b0, 6'd0, 1);
    drive(1'b1, 1'b0, 6'd0, 1);
    drive(1'b1, 1'b1, 6'd0, 1);
    check("ce_1001", q, PEN ? 8'd7 : 8'd10);
    drive(1'b0, 1'b1, 6'd0, 1);
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) != 0);
      ce = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) s = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 4));
      @(negedge c);
      check("random", q, 8'(mq));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multilayer_counter.md
# multilayer_counter

Free-running 8-bit up-counter with a programmable 6-bit prescaler and a clock enable. It is the top-level block of the counter design. The prescaler is the first layer and produces an advance tick. The 8-bit count is built from two cascaded 4-bit layers joined by a carry chain, and that count drives the output `q`.

## Interface
Parameters:
- `Q_WIDTH`, 8: output count width; must be a multiple of `LAYER_WIDTH`.
- `LAYER_WIDTH`, 4: width of one counter layer.
- `S_WIDTH`, 6: prescaler select width.

Ports:
- `c`, input, 1: clock; all state changes on rising edge.
- `r`, input, 1: reset; asynchronous, active-low.
- `ce`, input, 1: clock enable; active-high.
- `s`, input, 6: prescale select; `q` advances once per `s+1` enabled clocks.
- `q`, output, 8: counter value.

## Operation
- State:
  - prescaler register `p[5:0]`.
  - count register `q[7:0]`, held as two 4-bit layers.
- Reset (`r`=0): `p`=0 and `q`=0 immediately, regardless of clock. Both hold while `r` is low.
- On a rising `c` edge with `r`=1 and `ce`=0: hold all state.
- On a rising `c` edge with `r`=1 and `ce`=1:
  - If `p >= s`: `p` becomes 0 and the tick is asserted, so `q` becomes `q+1`.
  - Otherwise: `p` becomes `p+1` and `q` holds.
- Layer cascade:
  - The low layer increments on the tick.
  - The high layer increments when the tick coincides with the low layer being 4'hF.
  - The carry is combinational within the same edge.
- Wrap-around: `q` goes 255 -> 0 with no flag and no saturation.
- `s` is sampled every enabled edge, with no latching.
  - If `s` drops below the current `p`, the next enabled edge ticks immediately. This is guaranteed by the `>=` compare.
  - If `s` rises, counting continues from the current `p`.
- `s`=0: tick on every enabled edge, so `q` counts at the clock rate.

## Timing
- `q` is registered. The tick and the `q` update occur on the same edge; there are no combinational paths from inputs to `q`.
- After reset release with constant `s`=N and `ce`=1: first increment on the (N+1)th rising edge, then every N+1 edges.
- Reset deassertion is synchronised externally. The first edge after `r` rises counts as enabled edge 1.
- `ce` low stretches the period by exactly the number of disabled edges; `p` does not advance.

## Configuration
- `MLC_PRESCALE_EN` defined:
  - Prescaler present; behaviour as above.
- `MLC_PRESCALE_EN` undefined:
  - `s` is ignored and `p` is removed.
  - Tick equals `ce`, so `q` advances on every enabled edge, identical to `s`=0.

## Structure
- Package `mlc_pkg`: `Q_WIDTH`, `LAYER_WIDTH`, `S_WIDTH` default constants, plus a `layer_t` typedef (logic [LAYER_WIDTH-1:0]).
- Sub-module `mlc_layer`:
  - One `LAYER_WIDTH` counter with async active-low reset.
  - Carry-in input; count and carry-out outputs. Carry-out is carry-in AND all-ones.
  - Instantiated `Q_WIDTH/LAYER_WIDTH` times via generate; layer 0 carry-in = tick.
- The prescaler compare/reset logic lives in the top module.

## Test plan
- Reset: hold `r`=0 for 3 clocks with `ce`=1 and `s`=5 -> `q`=0 throughout. Then pulse `r` low asynchronously mid-cycle -> `q`=0 before the next edge.
- `s`=0, `ce`=1, 20 edges after reset -> `q`=20; continue to 256 edges -> `q`=0 (wrap). Check the carry from `q`=8'h0F to 8'h10.
- `s`=1 -> `q` increments every 2nd edge; after 12 edges `q`=6. `s`=2 -> every 3rd edge; after 12 edges `q`=4.
- Sequence `s`: 0 -> 1 -> 2 -> 1 -> 0, changed at random edges:
  - change 2->1 when `p`=2 -> increment on the very next edge, then period 2.
  - change to 0 -> increment every edge.
- `ce` toggled 1,0,0,1 with `s`=0 -> `q` advances only on the 2 enabled edges. With `s`=3, disabled edges do not advance `p`.
- Build without `MLC_PRESCALE_EN`, `s`=7 -> `q` increments every enabled edge.
